// File: rtl/mux_pipe_skid_reg.sv
// Registered pipeline stage with a two-entry skid buffer on a valid/ready handshake.
// Optional saturating stall counter is enabled by defining MUX_SKID_STALL_CNT_EN.
//
// state | meaning
// EMPTY | no word held, out_valid=0
// ONE   | one word in main register
// FULL  | main holds older word, skid holds younger word, in_ready=0

module mux_pipe_skid_reg #(
    parameter int p = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic [p:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [p:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready
`ifdef MUX_SKID_STALL_CNT_EN
    ,
    output logic [7:0]   stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t       state_q;
    logic [p:0]   main_q;
    logic [p:0]   skid_q;
    logic         in_acc;
    logic         out_acc;

    // Ready is decoded from state flops only, so no out_ready -> in_ready path.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign in_acc    = in_valid & in_ready;
    assign out_acc   = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_acc) begin
                        main_q  <= in_data;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (in_acc && out_acc) begin
                        main_q <= in_data;
                    end else if (in_acc) begin
                        skid_q  <= in_data;
                        state_q <= FULL;
                    end else if (out_acc) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_acc) begin
                        main_q  <= skid_q;
                        state_q <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

`ifdef MUX_SKID_STALL_CNT_EN
    logic [7:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 8'h00;
        end else if (flush) begin
            stall_cnt_q <= 8'h00;
        end else if (in_valid && !in_ready && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_q <= stall_cnt_q + 8'h01;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
